// File: rtl/uart_modem_mon.sv
`default_nettype none
// ============================================================================
// Module   : uart_modem_mon
// Purpose  : Modem-line monitor and driver for the UART. Synchronises the
//            active-low modem inputs, optionally debounces them, and tracks
//            each channel's level plus sticky edge-qualified change flags
//            that software clears on read. It raises a maskable interrupt,
//            drives registered active-low modem outputs and supports an
//            internal loopback mode.
// Options  : `define UART_MODEM_MON_FILTER_EN to compile in the per-channel
//            debounce filter (stability window of FilterCycles cycles).
// Ports    : clk_i        - clock
//            rst_ni       - asynchronous active-low reset
//            modem_ni     - asynchronous modem inputs, active-low
//            modem_no     - registered modem outputs, active-low
//            ctrl_i       - output control bits, active-high
//            loopback_i   - route the output register back to the inputs
//            edge_mode_i  - per-channel edge mode, 2 bits per channel
//                           (00 none, 01 assert, 10 deassert, 11 both)
//            irq_en_i     - per-channel interrupt enable
//            clear_i      - per-channel sticky-flag clear strobe
//            level_o      - current (filtered) level, 1 = line asserted
//            delta_o      - sticky change flags
//            irq_o        - interrupt
// Revision : 1.0 - initial release
// ============================================================================
module uart_modem_mon #(
    parameter int NrInputs     = 4,
    parameter int NrOutputs    = 2,
    parameter int NrSyncStages = 2,
    parameter int FilterCycles = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NrInputs-1:0]     modem_ni,
    output logic [NrOutputs-1:0]    modem_no,
    input  logic [NrOutputs-1:0]    ctrl_i,
    input  logic                    loopback_i,
    input  logic [2*NrInputs-1:0]   edge_mode_i,
    input  logic [NrInputs-1:0]     irq_en_i,
    input  logic [NrInputs-1:0]     clear_i,
    output logic [NrInputs-1:0]     level_o,
    output logic [NrInputs-1:0]     delta_o,
    output logic                    irq_o
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range check
    // ------------------------------------------------------------------------
    if ((NrInputs < 1) || (NrInputs > 16) ||
        (NrOutputs < 1) || (NrOutputs > 16) ||
        (NrSyncStages < 2) ||
        (FilterCycles < 2) || (FilterCycles > 255)) begin : g_param_err
        $error("uart_modem_mon: parameter out of range");
    end

    // ------------------------------------------------------------------------
    // Output control register and modem output drivers
    // ------------------------------------------------------------------------
    logic [NrOutputs-1:0] ctrl_q;
    logic [NrOutputs-1:0] modem_out_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q      <= '0;
            modem_out_q <= '1;
        end else begin
            ctrl_q      <= ctrl_i;
            // Pads are held inactive while looped back so the far end sees
            // nothing of the internal test traffic.
            modem_out_q <= loopback_i ? '1 : ~ctrl_i;
        end
    end

    assign modem_no = modem_out_q;

    // ------------------------------------------------------------------------
    // Per-channel synchroniser, source select and optional debounce
    // ------------------------------------------------------------------------
    logic [NrInputs-1:0] src;      // selected active-high source
    logic [NrInputs-1:0] level_d;
    logic [NrInputs-1:0] level_q;

    for (genvar i = 0; i < NrInputs; i++) begin : g_chan
        logic [NrSyncStages-1:0] sync_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[NrSyncStages-2:0], modem_ni[i]};
            end
        end

        // Loopback reads the registered control bit directly; it is already
        // synchronous, so the synchroniser chain is bypassed.
        assign src[i] = loopback_i ? ctrl_q[i % NrOutputs]
                                   : ~sync_q[NrSyncStages-1];

`ifdef UART_MODEM_MON_FILTER_EN
        localparam int CntW = $clog2(FilterCycles);

        logic [CntW-1:0] cnt_q;
        logic [CntW-1:0] cnt_d;
        logic            lvl_nxt;

        // The counter measures how long the source has disagreed with the
        // reported level. Any agreement restarts the window, so only a
        // disagreement lasting FilterCycles consecutive cycles flips level.
        always_comb begin
            cnt_d   = '0;
            lvl_nxt = level_q[i];
            if (src[i] != level_q[i]) begin
                if (cnt_q == CntW'(FilterCycles - 1)) begin
                    lvl_nxt = src[i];
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign level_d[i] = lvl_nxt;
`else
        assign level_d[i] = src[i];
`endif
    end

    // ------------------------------------------------------------------------
    // Edge qualification
    // ------------------------------------------------------------------------
    // Edges are detected on the next-level value so that level_o and the
    // matching delta_o bit update on the same clock edge.
    logic [NrInputs-1:0] edge_set;

    for (genvar i = 0; i < NrInputs; i++) begin : g_edge
        logic rise;
        logic fall;

        assign rise        =  level_d[i] & ~level_q[i];
        assign fall        = ~level_d[i] &  level_q[i];
        assign edge_set[i] = (rise & edge_mode_i[2*i]) |
                             (fall & edge_mode_i[2*i+1]);
    end

    // ------------------------------------------------------------------------
    // Level, sticky flags and interrupt
    // ------------------------------------------------------------------------
    logic [NrInputs-1:0] delta_d;
    logic [NrInputs-1:0] delta_q;
    logic                irq_d;
    logic                irq_q;

    // Set has priority over clear so an edge arriving with the read strobe
    // is not lost.
    assign delta_d = (delta_q & ~clear_i) | edge_set;
    assign irq_d   = |(delta_q & irq_en_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
            delta_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            delta_q <= delta_d;
            irq_q   <= irq_d;
        end
    end

    assign level_o = level_q;
    assign delta_o = delta_q;
    assign irq_o   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_modem_mon.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_modem_mon
// Purpose  : Self-checking bench for uart_modem_mon. Stimulus tasks push the
//            expected output values, tagged with the cycle at which they
//            must appear, onto a scoreboard queue; a monitor pops and
//            compares them on the falling clock edge.
// Options  : honours `define UART_MODEM_MON_FILTER_EN (filter latencies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_modem_mon;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int NS = 2;
    localparam int FC = 4;
`ifdef UART_MODEM_MON_FILTER_EN
    localparam int SW = FC;   // source change to level change
`else
    localparam int SW = 1;
`endif
    localparam int LAT = NS + SW;   // pad edge to level/delta
    localparam int LB  = 1 + SW;    // ctrl_i to level in loopback

    localparam int SEL_LVL = 0;
    localparam int SEL_DLT = 1;
    localparam int SEL_IRQ = 2;
    localparam int SEL_MDM = 3;

    logic              clk;
    logic              rst_ni;
    logic [NI-1:0]     modem_ni;
    logic [NO-1:0]     modem_no;
    logic [NO-1:0]     ctrl_i;
    logic              loopback_i;
    logic [2*NI-1:0]   edge_mode_i;
    logic [NI-1:0]     irq_en_i;
    logic [NI-1:0]     clear_i;
    logic [NI-1:0]     level_o;
    logic [NI-1:0]     delta_o;
    logic              irq_o;

    uart_modem_mon #(
        .NrInputs     (NI),
        .NrOutputs    (NO),
        .NrSyncStages (NS),
        .FilterCycles (FC)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .modem_ni    (modem_ni),
        .modem_no    (modem_no),
        .ctrl_i      (ctrl_i),
        .loopback_i  (loopback_i),
        .edge_mode_i (edge_mode_i),
        .irq_en_i    (irq_en_i),
        .clear_i     (clear_i),
        .level_o     (level_o),
        .delta_o     (delta_o),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic check_value(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_LVL: return 16'(level_o);
            SEL_DLT: return 16'(delta_o);
            SEL_IRQ: return 16'(irq_o);
            default: return 16'(modem_no);
        endcase
    endfunction

    task automatic sb_push(input int dc, input int sel, input logic [15:0] v,
                           input string tag);
        exp_t e;
        e.cyc = cyc + dc;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic sb_flush();
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check_value(e.tag, observe(e.sel), e.exp);
        end
    endtask

    always @(negedge clk) sb_flush();

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clear strobe sampled on the next edge; flag drops there, irq one later.
    task automatic pulse_clear(input logic [NI-1:0] mask,
                               input logic [15:0] exp_dlt,
                               input logic [15:0] exp_irq, input string tag);
        clear_i = mask;
        sb_push(1, SEL_DLT, exp_dlt, {tag, "_dlt"});
        sb_push(2, SEL_IRQ, exp_irq, {tag, "_irq"});
        step(1);
        clear_i = '0;
        step(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b1;
        modem_ni    = '1;
        ctrl_i      = '0;
        loopback_i  = 1'b0;
        edge_mode_i = '0;
        irq_en_i    = '0;
        clear_i     = '0;
        #1 rst_ni = 1'b0;
        #2;
        sb_push(0, SEL_MDM, 16'h0003, "init_mdm");
        sb_push(0, SEL_LVL, 16'h0000, "init_lvl");
        sb_push(0, SEL_DLT, 16'h0000, "init_dlt");
        sb_push(0, SEL_IRQ, 16'h0000, "init_irq");
        sb_flush();
        step(3);
        rst_ni = 1'b1;
        step(3);

        // ---------------- edge modes on channel 0 ----------------
        edge_mode_i = 8'h01;
        irq_en_i    = 4'h1;
        modem_ni    = 4'b1110;
        sb_push(LAT-1, SEL_LVL, 16'h0000, "m01_lvl_early");
        sb_push(LAT,   SEL_LVL, 16'h0001, "m01_lvl");
        sb_push(LAT,   SEL_DLT, 16'h0001, "m01_dlt");
        sb_push(LAT,   SEL_IRQ, 16'h0000, "m01_irq_early");
        sb_push(LAT+1, SEL_IRQ, 16'h0001, "m01_irq");
        step(LAT+2);
        pulse_clear(4'h1, 16'h0000, 16'h0000, "m01_clr");
        modem_ni = 4'b1111;
        sb_push(LAT,   SEL_LVL, 16'h0000, "m01_deas_lvl");
        sb_push(LAT,   SEL_DLT, 16'h0000, "m01_deas_dlt");
        sb_push(LAT+1, SEL_IRQ, 16'h0000, "m01_deas_irq");
        step(LAT+2);

        edge_mode_i = 8'h03;
        modem_ni    = 4'b1110;
        sb_push(LAT, SEL_DLT, 16'h0001, "m11_as_dlt");
        step(LAT+2);
        pulse_clear(4'h1, 16'h0000, 16'h0000, "m11_clr1");
        modem_ni = 4'b1111;
        sb_push(LAT, SEL_DLT, 16'h0001, "m11_de_dlt");
        step(LAT+2);
        pulse_clear(4'h1, 16'h0000, 16'h0000, "m11_clr2");

        edge_mode_i = 8'h00;
        modem_ni    = 4'b1110;
        sb_push(LAT, SEL_LVL, 16'h0001, "m00_as_lvl");
        sb_push(LAT, SEL_DLT, 16'h0000, "m00_as_dlt");
        step(LAT+2);
        modem_ni = 4'b1111;
        sb_push(LAT, SEL_LVL, 16'h0000, "m00_de_lvl");
        sb_push(LAT, SEL_DLT, 16'h0000, "m00_de_dlt");
        step(LAT+2);

        // ---------------- clear collision ----------------
        edge_mode_i = 8'h03;
        modem_ni    = 4'b1110;
        sb_push(LAT, SEL_DLT, 16'h0001, "col_pre_dlt");
        step(LAT+2);
        modem_ni = 4'b1111;
        step(LAT-1);
        clear_i = 4'h1;                 // lands on the deassert edge
        sb_push(1, SEL_LVL, 16'h0000, "col_lvl");
        sb_push(1, SEL_DLT, 16'h0001, "col_dlt");
        step(1);
        clear_i = '0;
        sb_push(1, SEL_DLT, 16'h0001, "col_hold_dlt");
        step(2);
        pulse_clear(4'h1, 16'h0000, 16'h0000, "col_clr2");

        // ---------------- pulse filtering on channel 1 ----------------
        edge_mode_i = 8'h0C;
`ifdef UART_MODEM_MON_FILTER_EN
        modem_ni = 4'b1101;
        sb_push(LAT+3, SEL_LVL, 16'h0000, "flt3_lvl");
        sb_push(LAT+3, SEL_DLT, 16'h0000, "flt3_dlt");
        step(3);
        modem_ni = 4'b1111;
        step(LAT+4);
        modem_ni = 4'b1101;
        sb_push(LAT-1, SEL_LVL, 16'h0000, "flt4_lvl_early");
        sb_push(LAT,   SEL_LVL, 16'h0002, "flt4_lvl");
        sb_push(LAT,   SEL_DLT, 16'h0002, "flt4_dlt");
        step(4);
        modem_ni = 4'b1111;
        sb_push(LAT, SEL_LVL, 16'h0000, "flt4_end_lvl");
        sb_push(LAT, SEL_DLT, 16'h0002, "flt4_end_dlt");
        step(LAT+2);
`else
        modem_ni = 4'b1101;
        sb_push(LAT, SEL_LVL, 16'h0002, "p1_lvl");
        sb_push(LAT, SEL_DLT, 16'h0002, "p1_dlt");
        step(1);
        modem_ni = 4'b1111;
        sb_push(LAT, SEL_LVL, 16'h0000, "p1_end_lvl");
        sb_push(LAT, SEL_DLT, 16'h0002, "p1_end_dlt");
        step(LAT+2);
`endif
        pulse_clear(4'h2, 16'h0000, 16'h0000, "flt_clr");

        // ---------------- loopback ----------------
        edge_mode_i = 8'hDB;            // ch3 11, ch2 01, ch1 10, ch0 11
        irq_en_i    = 4'h0;
        loopback_i  = 1'b1;
        ctrl_i      = 2'b01;
        modem_ni    = 4'b0000;          // must be ignored
        sb_push(1,    SEL_MDM, 16'h0003, "lb_mdm");
        sb_push(LB-1, SEL_LVL, 16'h0000, "lb_lvl_early");
        sb_push(LB,   SEL_LVL, 16'h0005, "lb_lvl");
        sb_push(LB,   SEL_DLT, 16'h0005, "lb_dlt");
        step(LB+4);
        sb_push(0, SEL_LVL, 16'h0005, "lb_lvl_hold");
        step(1);
        loopback_i = 1'b0;
        sb_push(1,  SEL_MDM, 16'h0002, "lbx_mdm");
        sb_push(SW, SEL_LVL, 16'h000F, "lbx_lvl");
        sb_push(SW, SEL_DLT, 16'h000D, "lbx_dlt");
        step(SW+3);
        modem_ni = 4'b1111;
        ctrl_i   = 2'b00;
        sb_push(LAT, SEL_LVL, 16'h0000, "lbr_lvl");
        sb_push(LAT, SEL_DLT, 16'h000F, "lbr_dlt");
        step(LAT+2);
        pulse_clear(4'hF, 16'h0000, 16'h0000, "lb_clr");

        // ---------------- independent channels ----------------
        edge_mode_i = 8'h55;
        irq_en_i    = 4'hA;
        modem_ni = 4'b1110;
        sb_push(LAT,   SEL_DLT, 16'h0001, "ind0_dlt");
        sb_push(LAT+1, SEL_IRQ, 16'h0000, "ind0_irq");
        step(LAT+2);
        modem_ni = 4'b1100;
        sb_push(LAT,   SEL_DLT, 16'h0003, "ind1_dlt");
        sb_push(LAT+1, SEL_IRQ, 16'h0001, "ind1_irq");
        step(LAT+2);
        modem_ni = 4'b1000;
        sb_push(LAT,   SEL_DLT, 16'h0007, "ind2_dlt");
        sb_push(LAT+1, SEL_IRQ, 16'h0001, "ind2_irq");
        step(LAT+2);
        modem_ni = 4'b0000;
        sb_push(LAT,   SEL_LVL, 16'h000F, "ind3_lvl");
        sb_push(LAT,   SEL_DLT, 16'h000F, "ind3_dlt");
        sb_push(LAT+1, SEL_IRQ, 16'h0001, "ind3_irq");
        step(LAT+2);
        pulse_clear(4'h2, 16'h000D, 16'h0001, "ind_clr1");
        pulse_clear(4'h8, 16'h0005, 16'h0000, "ind_clr3");
        pulse_clear(4'h1, 16'h0004, 16'h0000, "ind_clr0");
        pulse_clear(4'h4, 16'h0000, 16'h0000, "ind_clr2");

        // ---------------- mid-traffic reset ----------------
        edge_mode_i = 8'hFF;
        ctrl_i      = 2'b11;
        modem_ni    = 4'b1111;
        sb_push(1,     SEL_MDM, 16'h0000, "rst_pre_mdm");
        sb_push(LAT,   SEL_DLT, 16'h000F, "rst_pre_dlt");
        sb_push(LAT+1, SEL_IRQ, 16'h0001, "rst_pre_irq");
        step(LAT+2);
        modem_ni = 4'b0000;
        step(2);
        rst_ni = 1'b0;
        #1;
        sb_push(0, SEL_MDM, 16'h0003, "rst_mdm");
        sb_push(0, SEL_LVL, 16'h0000, "rst_lvl");
        sb_push(0, SEL_DLT, 16'h0000, "rst_dlt");
        sb_push(0, SEL_IRQ, 16'h0000, "rst_irq");
        sb_flush();
        step(3);
        rst_ni = 1'b1;
        sb_push(0, SEL_MDM, 16'h0003, "rel_mdm_hold");
        sb_push(1, SEL_MDM, 16'h0000, "rel_mdm");
        step(3);

        for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
        check_value("sb_drain", 16'(sb.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_modem_mon.md
# uart_modem_mon

Parametrised modem-line monitor and driver for the UART: synchronises `NrInputs` active-low modem inputs, optionally debounces them, and tracks per-channel level plus sticky, edge-qualified change flags that clear on software read. It also raises a maskable interrupt and drives `NrOutputs` registered active-low modem outputs, with a loopback mode. It sits between the pads and the UART register file; software owns all flow-control policy.

## Interface
- `NrInputs`, 4: number of modem input channels, 1..16.
- `NrOutputs`, 2: number of modem output channels, 1..16.
- `NrSyncStages`, 2: synchroniser depth per input, ≥2.
- `FilterCycles`, 4: debounce stability window in cycles, 2..255 (used only with the filter compiled in).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `modem_ni` in NrInputs: asynchronous modem inputs, active-low.
- `modem_no` out NrOutputs: modem outputs, active-low, registered.
- `ctrl_i` in NrOutputs: output control bits from the control register, active-high.
- `loopback_i` in 1: loopback enable.
- `edge_mode_i` in 2*NrInputs: per-channel edge mode (bits 2i+1:2i). 00 = none, 01 = assert, 10 = deassert, 11 = both.
- `irq_en_i` in NrInputs: per-channel interrupt enable.
- `clear_i` in NrInputs: one-cycle pulse per bit that clears that channel's sticky flag (the register-read strobe).
- `level_o` out NrInputs: current filtered level, active-high (1 = line asserted).
- `delta_o` out NrInputs: sticky change flags.
- `irq_o` out 1: interrupt.

## Operation
- **Source select:**
  - `loopback_i` = 0: channel i takes the synchronised, inverted `modem_ni[i]`.
  - `loopback_i` = 1: channel i takes `ctrl_q[i % NrOutputs]`, the internal active-high output register. This bypasses the synchronisers, and `modem_no` is forced to all ones.
- **Level stage:** `level_q[i]` follows the selected source (filter compiled out) or the debounced source (filter compiled in; see Configuration).
- **Edge detect:** evaluated on the cycle `level_q[i]` changes. 0→1 is an assert edge and 1→0 is a deassert edge. The flag `delta_q[i]` is set when the edge type is enabled by `edge_mode_i`; mode 00 never sets it.
- **Clear:** `clear_i[i]` resets `delta_q[i]` on the next edge. If an enabled edge and a clear occur in the same cycle, set wins, so no event is lost.
- **Interrupt:** `irq_o` is registered `|(delta_q & irq_en_i)`.
- **Output register:** `ctrl_q` is registered from `ctrl_i` every cycle. `modem_no` is registered as `~ctrl_i`, or all ones in loopback.
- **Loopback toggle:** toggling `loopback_i` can change the source. The resulting level changes are reported as normal edges.
- **Mid-operation reset:** a reset in the middle of operation returns every register to its reset value immediately (asynchronous). Partial filter counts are discarded.

## Timing
- **Reset values:**
  - synchroniser flops = 1 (inactive);
  - `level_o` = 0, `delta_o` = 0, `irq_o` = 0;
  - `modem_no` = all ones;
  - `ctrl_q` = 0;
  - filter counters = 0.
- **Latency:**
  - Pad edge to `level_o`/`delta_o`: NrSyncStages+1 rising edges (filter out), or NrSyncStages+FilterCycles (filter in). `level_o` and `delta_o` update on the same edge.
  - `delta_o` to `irq_o`: +1 edge.
  - `ctrl_i` to `modem_no`: 1 edge.
  - Loopback path `ctrl_i` to `level_o`: 2 edges (filter out).
- **Clear:** `clear_i` high at edge k makes `delta_o` low after edge k and `irq_o` low after k+1, unless a new enabled edge lands at edge k.

## Configuration
- **Macro `UART_MODEM_MON_FILTER_EN`:**
  - **Defined:** each channel has a counter of width $clog2(FilterCycles).
    - The counter is cleared while source == `level_q`, and increments while they differ.
    - When it reaches FilterCycles-1 with source still differing, `level_q` flips on that edge and the counter clears.
    - A pulse shorter than FilterCycles cycles is never reported.
  - **Undefined:** there are no counters, `level_q` follows the source with 1 cycle delay, and `FilterCycles` is ignored.

## Test plan
- **Reset state:** assert `rst_ni`=0 mid-traffic with `ctrl_i`=2'b11. Required: `modem_no`=2'b11, `level_o`=0, `delta_o`=0 and `irq_o`=0 immediately. `modem_no`=2'b00 one edge after release.
- **Edge modes:** drive `modem_ni[0]` 1→0→1 with `edge_mode_i[1:0]`=01, and `irq_en_i[0]`=1.
  - The assert sets `delta_o[0]` at NrSyncStages+1 edges (filter out), or NrSyncStages+FilterCycles edges (filter in). `irq_o` follows 1 edge later.
  - The deassert does not re-set the flag after a clear.
  - With mode 11 both transitions set it; with mode 00 neither does.
- **Clear collision:** pulse `clear_i[0]` on the same edge an enabled edge registers. Required: `delta_o[0]` stays 1. A second clear with no edge gives `delta_o[0]`=0.
- **Filter (macro defined, FilterCycles=4):**
  - A 3-cycle low pulse on `modem_ni[1]` leaves `level_o[1]`=0 and `delta_o[1]`=0.
  - A 4-cycle low pulse sets `level_o[1]`=1 and `delta_o[1]`=1.
  - Macro undefined: a 1-cycle pulse is reported.
- **Loopback:** `loopback_i`=1, `ctrl_i`=2'b01, NrInputs=4. Required:
  - `modem_no`=2'b11;
  - `level_o`=4'b0101 regardless of `modem_ni`;
  - channels that changed level show `delta_o` set for enabled edges.
- **Independent channels:** toggle all 4 inputs on different cycles with distinct `irq_en_i`=4'b1010. Required: `irq_o` asserts only for channels 1/3, and each `delta_o` bit clears independently.
